rmii_tx: RTL
============

# rmii_tx

RMII 100 Mb/s frame transmitter: takes a byte stream (destination MAC through payload) and drives the PHY transmit pins `tx_d`/`tx_e`. It adds preamble, SFD, zero padding to minimum frame size, CRC-32 FCS and inter-frame gap. It sits between the MAC-side packet source and the RMII pins, in the PHY reference-clock domain. It is the transmit counterpart of the RMII receive path already in the design.

## Interface
- `IFG_BYTES`, 12: inter-frame gap in byte times; 4 cycles per byte.
- `MIN_FRAME`, 60: minimum bytes before FCS; shorter frames are zero-padded.
- `PAD_EN`, 1: 1 enables padding; 0 sends frames as given.

- `clk_50_mhz`  in  1  RMII reference clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data`  in  8  frame byte.
- `s_valid`  in  1  `s_data` is valid; held until accepted.
- `s_last`  in  1  marks the final byte of the frame; qualified by `s_valid`.
- `s_ready`  out  1  byte is accepted in this cycle when `s_valid && s_ready`.
- `tx_d`  out  2  RMII transmit dibit.
- `tx_e`  out  1  RMII transmit enable.
- `busy`  out  1  high from the first preamble cycle to the end of the IFG.
- `frame_done`  out  1  one-cycle pulse when a frame completes normally.
- `underrun`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
- Each byte is sent as four dibits, LSB first: [1:0], [3:2], [5:4], [7:6].
- IDLE: `tx_e`=0, `tx_d`=0, `s_ready`=0. When `s_valid`=1, go to PREAMBLE.
- PREAMBLE: 7 bytes of 0x55, 28 cycles. Then SFD.
- SFD: 0xD5, 4 cycles. `s_ready`=1 on the 4th cycle to accept the first data byte. Then DATA.
- DATA:
  - `s_ready`=1 on the 4th dibit cycle of each byte, except the byte flagged `s_last`.
  - The accepted byte starts on the next cycle.
  - If `s_valid`=0 when `s_ready`=1: underrun. Pulse `underrun`, drop `tx_e` next cycle, go to IFG. No FCS is sent, so the receiver sees a bad CRC.
  - After the `s_last` byte: go to PAD if `PAD_EN` and byte count < `MIN_FRAME`, else FCS.
- PAD: send 0x00 bytes until byte count = `MIN_FRAME`. Then FCS.
- FCS:
  - CRC is reflected CRC-32, polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - CRC covers data and pad bytes only; preamble and SFD are excluded.
  - The register is updated per byte (or per dibit, with identical result).
  - Send `~crc` LSB first as 4 bytes, 16 cycles.
- IFG: `tx_e`=0 for `IFG_BYTES*4` cycles.
  - `frame_done` pulses in the first IFG cycle after FCS.
  - The IFG always runs to completion; `s_valid` is ignored until IDLE.
  - Then IDLE. A pending `s_valid` starts the next frame immediately.
- Byte counter: 11 bits, saturates at 2047. No maximum length is enforced.
- `s_last` on the first byte is legal: a 1-byte frame, padded to 60 when `PAD_EN`=1.
- Reset at any time: async clear to IDLE. All outputs go to 0 at once; any frame in flight is truncated with no FCS.

## Timing
- Reset values: `tx_d`=0, `tx_e`=0, `s_ready`=0, `busy`=0, `frame_done`=0, `underrun`=0. CRC register = 0xFFFFFFFF.
- All outputs are registered.
- Cycle numbering for a frame, with `s_valid` first seen high in IDLE at cycle 0:
  - cycle 1: first preamble dibit, `tx_e`=1, `busy`=1.
  - cycles 29–32: SFD.
  - cycle 32: `s_ready`=1.
  - cycle 33: first data dibit.
- A 60-byte frame holds `tx_e` high for 288 cycles: 32 preamble/SFD + 240 data + 16 FCS.
- `busy` falls 48 cycles after `tx_e` falls (default IFG).
- Back-to-back frames: the second `tx_e` rises 49 cycles after the first falls (48 IFG cycles + 1 IDLE cycle).

## Test plan
- Reset, then idle 100 cycles → `tx_e`=0, `tx_d`=0, `busy`=0 throughout.
- `PAD_EN`=0, payload ASCII "123456789" → wire carries 55×7, D5, 31..39, then FCS bytes 26 39 F4 CB. `tx_e` high for 32+36+16 = 84 cycles. One `frame_done` pulse.
- `PAD_EN`=1, 14-byte frame → 46 zero bytes of pad, then FCS. Running the CRC over data+pad+FCS leaves residue 0xDEBB20E3. `tx_e` high for 288 cycles.
- Two 64-byte frames with `s_valid` held high → exactly 48 `tx_e`=0 cycles in the IFG, plus one IDLE cycle between frames. Both FCS correct.
- `s_valid` dropped for one byte slot mid-payload → `underrun` pulses, `tx_e` falls next cycle, no FCS, no `frame_done`. After the IFG the next frame transmits correctly.
- `rst` asserted mid-DATA → `tx_e`=0 in the same cycle (asynchronous clear). A new frame after release starts cleanly with the preamble.

Source files
------------

// File: rtl/rmii_tx_if.sv
// rmii_tx_if: MAC-side byte stream feeding the RMII transmitter.
// master = packet source (data/valid/last), slave = rmii_tx (ready).
interface rmii_tx_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/rmii_tx.sv
// rmii_tx: RMII 100 Mb/s frame transmitter (preamble, SFD, pad, FCS, IFG).
// Ports: clk_50_mhz/rst, s (byte stream slave), tx_d/tx_e, busy, frame_done, underrun.
module rmii_tx #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60,
  parameter int PAD_EN    = 1
) (
  input  logic       clk_50_mhz,
  input  logic       rst,
  rmii_tx_if.slave   s,
  output logic [1:0] tx_d,
  output logic       tx_e,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES * 4 - 1);
  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
  localparam bit          DO_PAD   = (PAD_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } state_t;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  state_t      state_q, state_n;
  logic [1:0]  dcnt_q, dcnt_n;
  logic [15:0] cnt_q, cnt_n;
  logic [7:0]  cur_q, cur_n;
  logic        last_q, last_n;
  logic [10:0] len_q, len_n;
  logic [31:0] crc_q, crc_n;
  logic        rdy_q;

  logic        take, abort, pad, to_fcs;
  logic        done_n, und_n;
  logic [10:0] len_inc;
  logic [31:0] fcs;
  logic        tx_on_n;
  logic        rdy_n;
  logic [7:0]  sh;
  logic [1:0]  tx_d_n;

  assign s.s_ready = rdy_q;

  // Next-state: the registered outputs are derived from these values,
  // so every output reflects the state it is emitted in.
  always_comb begin
    state_n = state_q;
    dcnt_n  = dcnt_q;
    cnt_n   = cnt_q;
    cur_n   = cur_q;
    last_n  = last_q;
    len_n   = len_q;
    crc_n   = crc_q;
    take    = 1'b0;
    abort   = 1'b0;
    pad     = 1'b0;
    to_fcs  = 1'b0;
    done_n  = 1'b0;
    und_n   = 1'b0;
    len_inc = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
    fcs     = ~crc_q;

    unique case (state_q)
      IDLE: begin
        if (s.s_valid) begin
          state_n = PREAMBLE;
          dcnt_n  = '0;
          cnt_n   = '0;
          cur_n   = 8'h55;
          last_n  = 1'b0;
          len_n   = '0;
          crc_n   = '1;
        end
      end
      PREAMBLE: begin
        dcnt_n = dcnt_q + 2'd1;
        if (dcnt_q == 2'd3) begin
          if (cnt_q == 16'd6) begin
            state_n = SFD;
            cur_n   = 8'hD5;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 16'd1;
          end
        end
      end
      SFD: begin
        dcnt_n = dcnt_q + 2'd1;
        if (dcnt_q == 2'd3) begin
          if (s.s_valid) take  = 1'b1;
          else           abort = 1'b1;
        end
      end
      DATA: begin
        dcnt_n = dcnt_q + 2'd1;
        if (dcnt_q == 2'd3) begin
          // ready was offered this cycle unless the byte was the last
          if (rdy_q) begin
            if (s.s_valid) take  = 1'b1;
            else           abort = 1'b1;
          end else if (DO_PAD && len_q < MIN_LEN) begin
            pad = 1'b1;
          end else begin
            to_fcs = 1'b1;
          end
        end
      end
      PAD: begin
        dcnt_n = dcnt_q + 2'd1;
        if (dcnt_q == 2'd3) begin
          if (len_q < MIN_LEN) pad    = 1'b1;
          else                 to_fcs = 1'b1;
        end
      end
      FCS: begin
        dcnt_n = dcnt_q + 2'd1;
        if (dcnt_q == 2'd3) begin
          if (cnt_q == 16'd3) begin
            state_n = IFG;
            cnt_n   = '0;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt_q + 16'd1;
            unique case (cnt_q[1:0])
              2'd0:    cur_n = fcs[15:8];
              2'd1:    cur_n = fcs[23:16];
              default: cur_n = fcs[31:24];
            endcase
          end
        end
      end
      IFG: begin
        if (cnt_q == IFG_LAST) state_n = IDLE;
        else                   cnt_n   = cnt_q + 16'd1;
      end
      default: state_n = IDLE;
    endcase

    if (take) begin
      state_n = DATA;
      dcnt_n  = '0;
      cur_n   = s.s_data;
      last_n  = s.s_last;
      len_n   = len_inc;
      crc_n   = crc_byte(crc_q, s.s_data);
    end
    // starved mid-frame: cut the frame, no FCS
    if (abort) begin
      state_n = IFG;
      cnt_n   = '0;
      und_n   = 1'b1;
    end
    if (pad) begin
      state_n = PAD;
      dcnt_n  = '0;
      cur_n   = 8'h00;
      len_n   = len_inc;
      crc_n   = crc_byte(crc_q, 8'h00);
    end
    if (to_fcs) begin
      state_n = FCS;
      dcnt_n  = '0;
      cnt_n   = '0;
      cur_n   = fcs[7:0];
    end
  end

  always_comb begin
    tx_on_n = (state_n == PREAMBLE) ||
              (state_n == SFD) ||
              (state_n == DATA) ||
              (state_n == PAD) ||
              (state_n == FCS);
    sh      = cur_n >> {dcnt_n, 1'b0};
    tx_d_n  = tx_on_n ? sh[1:0] : 2'b00;
    rdy_n   = (dcnt_n == 2'd3) &&
              ((state_n == SFD) ||
               (state_n == DATA && !last_n));
  end

  always_ff @(posedge clk_50_mhz or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dcnt_q     <= '0;
      cnt_q      <= '0;
      cur_q      <= '0;
      last_q     <= 1'b0;
      len_q      <= '0;
      crc_q      <= '1;
      rdy_q      <= 1'b0;
      tx_d       <= '0;
      tx_e       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_n;
      dcnt_q     <= dcnt_n;
      cnt_q      <= cnt_n;
      cur_q      <= cur_n;
      last_q     <= last_n;
      len_q      <= len_n;
      crc_q      <= crc_n;
      rdy_q      <= rdy_n;
      tx_d       <= tx_d_n;
      tx_e       <= tx_on_n;
      busy       <= (state_n != IDLE);
      frame_done <= done_n;
      underrun   <= und_n;
    end
  end

endmodule
